// File: rtl/com_pkg.sv
// Shared definitions for the req/grant/w_en link: FSM state encoding and default
// link data width.
package com_pkg;

    localparam int unsigned DSIZE_DEF = 8;

    // Five states need three bits.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        DATA  = 3'd2,
        REST1 = 3'd3,
        REST2 = 3'd4
    } state_t;

endpackage

// File: rtl/com_tx_fsm.sv
// Transmit end of the req/grant/w_en link: drains a show-ahead FIFO and streams
// bursts of up to MAX_BURST words after the receiver grants the link.
module com_tx_fsm
    import com_pkg::*;
#(
    parameter int unsigned DSIZE     = DSIZE_DEF,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             r_en,
    output logic             req,
    output logic [DSIZE-1:0] dout,
    input  logic             grant,
    output logic             busy,
    output logic             proto_err
);

    localparam int unsigned   CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    state_t           r_state;
    state_t           w_next;
    logic             r_req;
    logic [DSIZE-1:0] r_dout;
    logic [DSIZE-1:0] r_hold;
    logic [CW-1:0]    r_cnt;
    logic             r_perr;

    logic             w_ren;
    logic             w_start;
    logic             w_load;
    logic             w_more;

    always_comb begin
        w_next  = r_state;
        w_ren   = 1'b0;
        w_start = 1'b0;
        w_load  = 1'b0;
        w_more  = !rempty && (r_cnt < MAXC);
        case (r_state)
            IDLE: begin
                if (!rempty) begin
                    w_ren   = 1'b1;
                    w_start = 1'b1;
                    w_next  = ARB;
                end
            end
            ARB: begin
                if (grant) begin
                    w_load = 1'b1;
                    w_next = DATA;
                end
            end
            DATA: begin
                if (r_req) begin
                    w_load = 1'b1;
                end else begin
                    w_next = REST1;
                end
            end
            REST1:   w_next = REST2;
            REST2:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Every load cycle may refill the hold register for the following cycle.
        if (w_load && w_more) begin
            w_ren = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_dout  <= '0;
            r_hold  <= '0;
            r_cnt   <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_hold <= rdata;
                r_cnt  <= CW'(1);
                r_req  <= 1'b1;
            end
            if (w_load) begin
                r_dout <= r_hold;
                if (w_more) begin
                    r_hold <= rdata;
                    r_cnt  <= r_cnt + CW'(1);
                    r_req  <= 1'b1;
                end else begin
                    r_req  <= 1'b0;
                end
            end
            if (r_state == DATA && grant != r_req) begin
                r_perr <= 1'b1;
            end
        end
    end

    // The pop strobe is combinational, so it is gated by reset to stay low while held.
    assign r_en      = w_ren && rrst_n;
    assign req       = r_req;
    assign dout      = r_dout;
    assign busy      = (r_state != IDLE);
    assign proto_err = r_perr;

endmodule

// File: tb/tb_com_tx_fsm.sv
// Self-checking bench for com_tx_fsm: queue-based FIFO, receiver model and a
// burst-level reference model compared every cycle, plus directed literal checks.
module tb_com_tx_fsm;

    localparam int DSIZE = 8;
    localparam int MAXB  = 16;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             r_en;
    logic             req;
    logic [DSIZE-1:0] dout;
    logic             grant;
    logic             busy;
    logic             proto_err;

    always #5 rclk = ~rclk;

    com_tx_fsm #(.DSIZE(DSIZE), .MAX_BURST(MAXB)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rdata     (rdata),
        .rempty    (rempty),
        .r_en      (r_en),
        .req       (req),
        .dout      (dout),
        .grant     (grant),
        .busy      (busy),
        .proto_err (proto_err)
    );

    // Live stimulus (stable for a whole cycle) and caller requests for the next cycle.
    bit allow, pess, force_lo;
    bit c_allow, c_pess, c_force;
    int inq[$];

    int fifo[$];
    int expq[$];
    bit pop_pend;

    // Reference model: receiver phase plus transmitter "request pending" flag.
    bit m_data, m_armed, m_more, m_perr;
    int m_rest, m_n, m_dout;
    bit p_data, p_armed, p_more, p_perr;
    int p_rest, p_n, p_dout;

    int checks, passed, cyc;
    int bursts[$];
    int gaps[$];
    int pops, req_hi, last_data;
    bit prev_req;

    // Receiver grants when idle (and willing) and keeps grant==req while writing.
    assign grant = !force_lo && req && (m_data || (m_rest == 0 && allow));

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endfunction

    task automatic model_reset();
        m_data = 0; m_armed = 0; m_more = 0; m_perr = 0; m_rest = 0; m_n = 0; m_dout = 0;
        p_data = 0; p_armed = 0; p_more = 0; p_perr = 0; p_rest = 0; p_n = 0; p_dout = 0;
        fifo.delete(); expq.delete(); inq.delete();
        pop_pend = 0; prev_req = 0; last_data = -1000;
    endtask

    task automatic clear_stats();
        bursts.delete(); gaps.delete(); pops = 0; req_hi = 0;
    endtask

    task automatic step();
        int  ncur;
        bit  e_busy, e_req, e_ren;
        int  e_dout;
        @(negedge rclk);
        cyc++;
        if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
        pop_pend = 0;
        m_data = p_data; m_armed = p_armed; m_more = p_more; m_perr = p_perr;
        m_rest = p_rest; m_n = p_n; m_dout = p_dout;
        allow = c_allow; pess = c_pess; force_lo = c_force;
        while (inq.size() > 0) begin
            fifo.push_back(inq[0]);
            expq.push_back(inq[0]);
            void'(inq.pop_front());
        end
        rempty = (fifo.size() == 0) || pess;
        rdata  = (fifo.size() > 0) ? DSIZE'(fifo[0]) : '0;
        #1;
        ncur   = m_n + 1;
        e_busy = m_armed || m_data || (m_rest > 0);
        e_req  = m_armed || (m_data && m_more);
        e_dout = m_data ? ((expq.size() > 0) ? expq[0] : -1) : m_dout;
        if (m_data)           e_ren = e_req && !rempty && (ncur + 1 < MAXB);
        else if (m_armed)     e_ren = grant && !rempty && (1 < MAXB);
        else if (m_rest > 0)  e_ren = 0;
        else                  e_ren = !rempty;
        chk("busy", int'(busy), int'(e_busy));
        chk("req", int'(req), int'(e_req));
        chk("dout", int'(dout), e_dout);
        chk("r_en", int'(r_en), int'(e_ren));
        chk("proto_err", int'(proto_err), int'(m_perr));
        if (req) req_hi++;
        if (r_en) pops++;
        pop_pend = r_en;
        if (req && !prev_req && last_data >= 0) begin
            gaps.push_back(cyc - last_data - 1);
            chk("req_gap_ge3", int'(cyc - last_data - 1 >= 3), 1);
        end
        prev_req = req;
        p_perr = m_perr || (m_data && (grant != e_req));
        if (m_data) begin
            p_n    = ncur;
            p_dout = e_dout;
            if (expq.size() > 0) void'(expq.pop_front());
            if (e_req) begin
                p_more = !rempty && (ncur + 1 < MAXB);
            end else begin
                p_data = 0;
                p_rest = 2;
                bursts.push_back(ncur);
                last_data = cyc;
            end
        end else if (m_armed) begin
            if (grant) begin
                p_armed = 0; p_data = 1; p_n = 0;
                p_more  = !rempty && (1 < MAXB);
            end
        end else if (m_rest > 0) begin
            p_rest = m_rest - 1;
        end else if (!rempty) begin
            p_armed = 1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(negedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("rst_req", int'(req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_r_en", int'(r_en), 0);
        model_reset();
        rempty = 1'b1; rdata = '0;
        allow = 1; pess = 0; force_lo = 0;
        c_allow = 1; c_pess = 0; c_force = 0;
        @(negedge rclk);
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        int guard;
        checks = 0; passed = 0; cyc = 0;
        rrst_n = 1'b0; rempty = 1'b1; rdata = '0;
        model_reset();
        clear_stats();

        // Single word.
        do_reset(); clear_stats();
        inq.push_back(8'h5A);
        run(12);
        chk("t1_pops", pops, 1);
        chk("t1_req_cycles", req_hi, 1);
        chk("t1_nbursts", bursts.size(), 1);
        chk("t1_len", (bursts.size() > 0) ? bursts[0] : -1, 1);
        chk("t1_dout", int'(dout), 8'h5A);

        // Three-word burst.
        do_reset(); clear_stats();
        inq.push_back(1); inq.push_back(2); inq.push_back(3);
        run(15);
        chk("t2_req_cycles", req_hi, 3);
        chk("t2_len", (bursts.size() == 1) ? bursts[0] : -1, 3);
        chk("t2_dout", int'(dout), 3);

        // 20 words split at MAX_BURST.
        do_reset(); clear_stats();
        for (int i = 0; i < 20; i++) inq.push_back(8'h80 + i);
        run(60);
        chk("t3_nbursts", bursts.size(), 2);
        chk("t3_len0", (bursts.size() > 0) ? bursts[0] : -1, 16);
        chk("t3_len1", (bursts.size() > 1) ? bursts[1] : -1, 4);
        chk("t3_gap", (gaps.size() > 0) ? gaps[0] : -1, 3);
        chk("t3_left", expq.size(), 0);

        // Grant withheld for five ARB cycles.
        do_reset(); clear_stats();
        c_allow = 0;
        inq.push_back(8'h77);
        run(6);
        chk("t4_pops_stalled", pops, 1);
        chk("t4_dout_stalled", int'(dout), 0);
        c_allow = 1;
        run(10);
        chk("t4_req_cycles", req_hi, 6);
        chk("t4_len", (bursts.size() == 1) ? bursts[0] : -1, 1);
        chk("t4_dout", int'(dout), 8'h77);

        // FIFO runs dry mid-burst.
        do_reset(); clear_stats();
        inq.push_back(8'hA1); inq.push_back(8'hA2);
        run(10);
        inq.push_back(8'hB1); inq.push_back(8'hB2); inq.push_back(8'hB3);
        run(15);
        chk("t5_nbursts", bursts.size(), 2);
        chk("t5_len0", (bursts.size() > 0) ? bursts[0] : -1, 2);
        chk("t5_len1", (bursts.size() > 1) ? bursts[1] : -1, 3);

        // Reset during DATA, then a protocol violation.
        do_reset(); clear_stats();
        for (int i = 0; i < 5; i++) inq.push_back(8'hC0 + i);
        guard = 0;
        do begin step(); guard++; end while (!m_data && guard < 20);
        chk("t6_reached_data", int'(m_data), 1);
        chk("t6_busy_before", int'(busy), 1);
        do_reset(); clear_stats();
        inq.push_back(8'hD1); inq.push_back(8'hD2); inq.push_back(8'hD3);
        guard = 0;
        do begin step(); guard++; end while (!(m_data && req) && guard < 20);
        chk("t6_reached_data_req", int'(m_data && req), 1);
        c_force = 1;
        step();
        c_force = 0;
        run(8);
        chk("t6_proto_err", int'(proto_err), 1);

        // Randomized traffic with random stalls and pessimistic empty.
        do_reset(); clear_stats();
        for (int i = 0; i < 3000; i++) begin
            c_allow = ($urandom_range(0, 3) != 0);
            c_pess  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0 && fifo.size() < 48) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) inq.push_back(int'($urandom_range(0, 255)));
            end
            step();
        end
        c_allow = 1; c_pess = 0;
        guard = 0;
        while ((expq.size() > 0 || busy) && guard < 500) begin step(); guard++; end
        chk("rand_drained", expq.size(), 0);
        chk("rand_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
